rom_streamer: RTL and testbench

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_streamer_pkg.sv | 9 +
 rtl/rom_streamer_if.sv | 14 +
 rtl/rom_streamer.sv | 118 +++++++++++
 tb/tb_rom_streamer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_streamer_pkg.sv
// Shared types for the ROM burst streamer.
package rom_streamer_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage : rom_streamer_pkg

// File: rtl/rom_streamer_if.sv
// Valid/ready output stream of the ROM streamer (master = streamer, slave = consumer).
interface rom_streamer_if #(
  parameter int WIDTH = 5
);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface : rom_streamer_if

// File: rtl/rom_streamer.sv
// Streams a burst of words from an external combinational ROM onto a valid/ready port.
// Optional build macro ROM_STREAMER_CHECKSUM_EN adds an XOR checksum of accepted words.
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          count,
  output logic [AW-1:0]        raddr,
  input  logic [WIDTH-1:0]     rdata,
  rom_streamer_if.master       st,
  output logic                 busy,
`ifdef ROM_STREAMER_CHECKSUM_EN
  output logic [WIDTH-1:0]     checksum,
`endif
  output logic                 done
);

  state_t           state, state_d;
  logic [AW-1:0]    ptr, ptr_d;
  logic [AW:0]      rem, rem_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             hs;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  assign hs    = valid_q && st.out_ready;
  assign raddr = (state == STREAM) ? ptr : base_addr;

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d = state;
    ptr_d   = ptr;
    rem_d   = rem;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            data_d  = rdata;
            ptr_d   = wrap_inc(base_addr);
            rem_d   = count;
            valid_d = 1'b1;
            state_d = STREAM;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      STREAM: begin
        if (hs) begin
          if (rem > (AW+1)'(1)) begin
            data_d = rdata;
            ptr_d  = wrap_inc(ptr);
            rem_d  = rem - (AW+1)'(1);
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      rem     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      rem     <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

`ifdef ROM_STREAMER_CHECKSUM_EN
  // Cleared on any start accepted in IDLE, then folds in each handshaken word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum ^ data_q;
    end
  end
`endif

  assign st.out_valid = valid_q;
  assign st.out_data  = data_q;
  assign st.out_last  = valid_q && (rem == (AW+1)'(1));
  assign busy         = (state == STREAM);
  assign done         = done_q;

endmodule : rom_streamer

// File: tb/tb_rom_streamer.sv
// Directed bench for rom_streamer with a 4x5 ROM holding 5, 0, 21, 11.
// Define ROM_STREAMER_CHECKSUM_EN to also exercise the checksum output.
module tb_rom_streamer;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] base_addr = '0;
  logic [2:0] count = '0;
  logic [1:0] raddr;
  logic [4:0] rdata;
  logic       busy;
  logic       done;
`ifdef ROM_STREAMER_CHECKSUM_EN
  logic [4:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  rom_streamer_if #(.WIDTH(5)) st ();

  rom_streamer #(.DEPTH(4), .WIDTH(5)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .raddr     (raddr),
    .rdata     (rdata),
    .st        (st.master),
    .busy      (busy),
`ifdef ROM_STREAMER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (raddr)
      2'd0:    rdata = 5'd5;
      2'd1:    rdata = 5'd0;
      2'd2:    rdata = 5'd21;
      default: rdata = 5'd11;
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    st.out_ready = 1'b1;
    #3;
    checks++;
    if ({st.out_valid, st.out_last, busy, done} !== 4'b0000 || st.out_data !== 5'd0) begin
      $display("FAIL reset: valid/last/busy/done=%b data=%0d, want 0000 and 0",
               {st.out_valid, st.out_last, busy, done}, st.out_data);
      errors++;
    end
`ifdef ROM_STREAMER_CHECKSUM_EN
    checks++;
    if (checksum !== 5'd0) begin
      $display("FAIL reset_checksum: got %0d want 0", checksum);
      errors++;
    end
`endif
    arst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    logic [4:0] exp [4] = '{5'd5, 5'd0, 5'd21, 5'd11};
    base_addr = 2'd0; count = 3'd4; start = 1'b1; st.out_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st.out_valid !== 1'b1 || st.out_data !== exp[i] || st.out_last !== (i == 3) ||
          done !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL basic_beat%0d: v=%b d=%0d last=%b done=%b busy=%b want v=1 d=%0d last=%b done=0 busy=1",
                 i, st.out_valid, st.out_data, st.out_last, done, busy, exp[i], (i == 3));
        errors++;
      end
      cyc();
    end
    checks++;
    if (st.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL basic_done: v=%b done=%b busy=%b want 0 1 0", st.out_valid, done, busy);
      errors++;
    end
`ifdef ROM_STREAMER_CHECKSUM_EN
    checks++;
    if (checksum !== 5'd27) begin
      $display("FAIL basic_checksum: got %0d want 27", checksum);
      errors++;
    end
`endif
    cyc();
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL basic_done_width: done=%b want 0", done);
      errors++;
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp [3] = '{5'd11, 5'd5, 5'd0};
    base_addr = 2'd3; count = 3'd3; start = 1'b1; st.out_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st.out_valid !== 1'b1 || st.out_data !== exp[i] || st.out_last !== (i == 2)) begin
        $display("FAIL wrap_beat%0d: v=%b d=%0d last=%b want v=1 d=%0d last=%b",
                 i, st.out_valid, st.out_data, st.out_last, exp[i], (i == 2));
        errors++;
      end
      cyc();
    end
    checks++;
    if (st.out_valid !== 1'b0 || done !== 1'b1) begin
      $display("FAIL wrap_done: v=%b done=%b want 0 1", st.out_valid, done);
      errors++;
    end
    cyc();
  endtask

  task automatic test_backpressure();
    int dones = 0;
    base_addr = 2'd1; count = 3'd2; start = 1'b1; st.out_ready = 1'b0;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) st.out_ready = 1'b1;
      checks++;
      if (st.out_valid !== 1'b1 || st.out_data !== 5'd0 || st.out_last !== 1'b0) begin
        $display("FAIL hold%0d: v=%b d=%0d last=%b want v=1 d=0 last=0",
                 i, st.out_valid, st.out_data, st.out_last);
        errors++;
      end
      if (done) dones++;
      cyc();
    end
    checks++;
    if (st.out_valid !== 1'b1 || st.out_data !== 5'd21 || st.out_last !== 1'b1) begin
      $display("FAIL hold_second: v=%b d=%0d last=%b want v=1 d=21 last=1",
               st.out_valid, st.out_data, st.out_last);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done) dones++;
    end
    checks++;
    if (dones !== 1) begin
      $display("FAIL hold_done_count: got %0d pulses want 1", dones);
      errors++;
    end
  endtask

  task automatic test_zero_count();
    base_addr = 2'd2; count = 3'd0; start = 1'b1; st.out_ready = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (st.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL zero_first: v=%b done=%b busy=%b want 0 1 0", st.out_valid, done, busy);
      errors++;
    end
    cyc();
    checks++;
    if (st.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL zero_after: v=%b done=%b busy=%b want 0 0 0", st.out_valid, done, busy);
      errors++;
    end
  endtask

  task automatic test_busy_and_reset();
    logic [4:0] exp [3] = '{5'd5, 5'd0, 5'd21};
    base_addr = 2'd0; count = 3'd4; start = 1'b1; st.out_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        start = 1'b1; base_addr = 2'd2; count = 3'd1;
      end else begin
        start = 1'b0;
      end
      checks++;
      if (st.out_valid !== 1'b1 || st.out_data !== exp[i] || st.out_last !== 1'b0) begin
        $display("FAIL busy_ignore%0d: v=%b d=%0d last=%b want v=1 d=%0d last=0",
                 i, st.out_valid, st.out_data, st.out_last, exp[i]);
        errors++;
      end
      if (i < 2) cyc();
    end
    start = 1'b0;
    arst_n = 1'b0;
    #1;
    checks++;
    if (st.out_valid !== 1'b0 || busy !== 1'b0 || st.out_last !== 1'b0) begin
      $display("FAIL midreset: v=%b busy=%b last=%b want 0 0 0", st.out_valid, busy, st.out_last);
      errors++;
    end
    #2 arst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (done !== 1'b0 || st.out_valid !== 1'b0) begin
        $display("FAIL midreset_quiet%0d: done=%b v=%b want 0 0", i, done, st.out_valid);
        errors++;
      end
    end
    base_addr = 2'd2; count = 3'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (st.out_valid !== 1'b1 || st.out_data !== 5'd21 || st.out_last !== 1'b0) begin
      $display("FAIL post_reset0: v=%b d=%0d last=%b want 1 21 0", st.out_valid, st.out_data, st.out_last);
      errors++;
    end
    cyc();
    checks++;
    if (st.out_valid !== 1'b1 || st.out_data !== 5'd11 || st.out_last !== 1'b1) begin
      $display("FAIL post_reset1: v=%b d=%0d last=%b want 1 11 1", st.out_valid, st.out_data, st.out_last);
      errors++;
    end
    cyc();
    checks++;
    if (done !== 1'b1 || st.out_valid !== 1'b0) begin
      $display("FAIL post_reset_done: done=%b v=%b want 1 0", done, st.out_valid);
      errors++;
    end
    cyc();
  endtask

  initial begin
    st.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_busy_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rom_streamer
